// File: rtl/alu_arbiter.sv
// Round-robin front end for one shared combinational ALU: two requesters, one
// operation in flight, registered ALU operands, masked N/Z/V flag register.
module alu_arbiter #(
  parameter int DATA_W = 16,
  parameter int OP_W   = 4,
  parameter int FLAG_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [OP_W-1:0]   req0_opcode,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [OP_W-1:0]   req1_opcode,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic [OP_W-1:0]   alu_opcode,
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [FLAG_W-1:0] alu_flags,
  input  logic [FLAG_W-1:0] alu_enable,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [FLAG_W-1:0] flag_reg,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic [FLAG_W-1:0]   flag_q, flag_d;
  logic                winner_s;
  logic                idle_s;

  // Grant selection; on a tie the requester that did not win last time goes.
  always_comb begin
    winner_s = 1'b0;
    if (req0_valid && req1_valid) begin
      winner_s = ~last_grant_q;
    end else if (req1_valid) begin
      winner_s = 1'b1;
    end else begin
      winner_s = 1'b0;
    end
    idle_s     = rst_n && (state_q == S_IDLE);
    req0_ready = idle_s && req0_valid && !winner_s;
    req1_ready = idle_s && req1_valid && winner_s;
  end

  // Next-state, issue capture, result capture and masked flag update.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    rsp_data_d   = rsp_data_q;
    flag_d       = flag_q;
    case (state_q)
      S_IDLE: begin
        if (req0_ready || req1_ready) begin
          state_d      = S_EXEC;
          last_grant_d = winner_s;
          op_d         = winner_s ? req1_opcode : req0_opcode;
          a_d          = winner_s ? req1_a : req0_a;
          b_d          = winner_s ? req1_b : req0_b;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_EXEC: begin
        rsp_data_d = alu_out;
        flag_d     = (flag_q & ~alu_enable) | (alu_flags & alu_enable);
        state_d    = S_RESP;
      end
      S_RESP: begin
        // Only the owner's ready releases the response.
        if (last_grant_q ? rsp1_ready : rsp0_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      op_q         <= {OP_W{1'b0}};
      a_q          <= {DATA_W{1'b0}};
      b_q          <= {DATA_W{1'b0}};
      rsp_data_q   <= {DATA_W{1'b0}};
      flag_q       <= {FLAG_W{1'b0}};
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      rsp_data_q   <= rsp_data_d;
      flag_q       <= flag_d;
    end
  end

  assign alu_opcode = op_q;
  assign alu_in1    = a_q;
  assign alu_in2    = b_q;
  assign rsp_data   = rsp_data_q;
  assign flag_reg   = flag_q;
  assign busy       = (state_q != S_IDLE);
  assign rsp0_valid = (state_q == S_RESP) && !last_grant_q;
  assign rsp1_valid = (state_q == S_RESP) && last_grant_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: a stub ALU, a table of single
// transactions, hand-written corner sequences and a randomized model run.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0]  req0_opcode, req1_opcode, alu_opcode;
  logic [15:0] req0_a, req0_b, req1_a, req1_b, alu_in1, alu_in2, alu_out, rsp_data;
  logic [2:0]  alu_flags, alu_enable, flag_reg;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready, busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
    .req1_a(req1_a), .req1_b(req1_b),
    .alu_opcode(alu_opcode), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_out(alu_out), .alu_flags(alu_flags), .alu_enable(alu_enable),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_data(rsp_data), .flag_reg(flag_reg), .busy(busy)
  );

  typedef struct packed {
    logic [15:0] d;
    logic [2:0]  f;
    logic [2:0]  en;
  } alu_res_t;

  // Behavioural ALU: flags are {N,Z,V}; en says which flags the op may write.
  function automatic alu_res_t alu_ref(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    alu_res_t r;
    logic v;
    v = 1'b0;
    case (op)
      4'd0: begin r.d = a + b; v = (a[15] == b[15]) && (r.d[15] != a[15]); r.en = 3'b111; end
      4'd1: begin r.d = a - b; v = (a[15] != b[15]) && (r.d[15] != a[15]); r.en = 3'b111; end
      4'd2: begin r.d = a ^ b; r.en = 3'b010; end
      4'd3: begin r.d = a & b; r.en = 3'b110; end
      default: begin r.d = a + b; r.en = 3'b000; end
    endcase
    r.f = {r.d[15], (r.d == 16'h0000), v};
    return r;
  endfunction

  alu_res_t stub_s;
  always_comb stub_s = alu_ref(alu_opcode, alu_in1, alu_in2);
  assign alu_out    = stub_s.d;
  assign alu_flags  = stub_s.f;
  assign alu_enable = stub_s.en;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic set_req(input bit r, input logic v, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    if (r) begin
      req1_valid = v; req1_opcode = op; req1_a = a; req1_b = b;
    end else begin
      req0_valid = v; req0_opcode = op; req0_a = a; req0_b = b;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One isolated operation with full timing checks from accept to return to idle.
  task automatic run_txn(input bit r, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] exp_d, input logic [2:0] exp_f);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    set_req(r, 1'b1, op, a, b);
    #1;
    chk("txn_ready", r ? req1_ready : req0_ready, 1'b1);
    chk("txn_other_ready", r ? req0_ready : req1_ready, 1'b0);
    @(negedge clk);
    set_req(r, 1'b0, op, a, b);
    #1;
    chk("exec_busy", busy, 1'b1);
    chk("exec_opcode", alu_opcode, op);
    chk("exec_in1", alu_in1, a);
    chk("exec_in2", alu_in2, b);
    chk("exec_no_rsp", {rsp1_valid, rsp0_valid}, 2'b00);
    @(negedge clk); #1;
    chk("rsp_valid", {rsp1_valid, rsp0_valid}, r ? 2'b10 : 2'b01);
    chk("rsp_data", rsp_data, exp_d);
    chk("rsp_flags", flag_reg, exp_f);
    @(negedge clk); #1;
    chk("back_idle", busy, 1'b0);
  endtask

  typedef struct {
    bit          r;
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp_d;
    logic [2:0]  exp_f;
  } vec_t;

  vec_t tbl[10];
  int   grants[$];

  // Randomized-phase state.
  logic        vr[2];
  logic [3:0]  opr[2];
  logic [15:0] ar[2], br[2];
  bit          acc[2];
  bit          outstanding, lg_m, owner, win, er0, er1;
  logic [2:0]  flags_m;
  logic [15:0] exp_d_m;
  int          age;
  alu_res_t    res;
  logic [3:0]  op_pool[8];

  initial begin
    tbl[0] = '{1'b0, 4'd0, 16'h0005, 16'h0007, 16'h000C, 3'b000};
    tbl[1] = '{1'b1, 4'd0, 16'h7FFF, 16'h0001, 16'h8000, 3'b101};
    tbl[2] = '{1'b0, 4'd2, 16'h1234, 16'h1234, 16'h0000, 3'b111};
    tbl[3] = '{1'b1, 4'd1, 16'h0009, 16'h0009, 16'h0000, 3'b010};
    tbl[4] = '{1'b0, 4'd8, 16'h0100, 16'h0004, 16'h0104, 3'b010};
    tbl[5] = '{1'b1, 4'd9, 16'h8000, 16'h0002, 16'h8002, 3'b010};
    tbl[6] = '{1'b0, 4'd15, 16'h0003, 16'h0004, 16'h0007, 3'b010};
    tbl[7] = '{1'b1, 4'd3, 16'hF0F0, 16'hFF00, 16'hF000, 3'b100};
    tbl[8] = '{1'b0, 4'd1, 16'h8000, 16'h0001, 16'h7FFF, 3'b001};
    tbl[9] = '{1'b1, 4'd0, 16'hFFFF, 16'h0001, 16'h0000, 3'b010};
    op_pool = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd8, 4'd9, 4'd15, 4'd5};

    // Reset values with both requesters asserting valid.
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_opcode = 4'd1; req0_a = 16'h1111; req0_b = 16'h2222;
    req1_opcode = 4'd2; req1_a = 16'h3333; req1_b = 16'h4444;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_ready", {req1_ready, req0_ready}, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rsp_valid", {rsp1_valid, rsp0_valid}, 2'b00);
    chk("rst_flags", flag_reg, 3'b000);
    chk("rst_alu_op", alu_opcode, 4'd0);
    chk("rst_alu_in1", alu_in1, 16'h0000);
    chk("rst_alu_in2", alu_in2, 16'h0000);
    chk("rst_rsp_data", rsp_data, 16'h0000);
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_txn(tbl[i].r, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp_d, tbl[i].exp_f);
    end

    // Simultaneous requests: grants alternate 0,1,0,1 starting after reset.
    do_reset();
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    set_req(1'b0, 1'b1, 4'd1, 16'h0009, 16'h0009);
    set_req(1'b1, 1'b1, 4'd0, 16'h0001, 16'h0001);
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (req0_ready) grants.push_back(0);
      if (req1_ready) grants.push_back(1);
      chk("sim_no_grant_busy", busy && (req0_ready || req1_ready), 1'b0);
      if (rsp0_valid) begin
        chk("sim_rsp0_data", rsp_data, 16'h0000);
        chk("sim_rsp0_flags", flag_reg, 3'b010);
      end
      if (rsp1_valid) begin
        chk("sim_rsp1_data", rsp_data, 16'h0002);
        chk("sim_rsp1_flags", flag_reg, 3'b000);
      end
    end
    chk("sim_grant_count", grants.size(), 4);
    for (int i = 0; i < grants.size() && i < 4; i++) chk("sim_grant_order", grants[i], i % 2);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (2) @(negedge clk);

    // Response backpressure on requester 1 with requester 0 pending.
    @(negedge clk);
    rsp0_ready = 1'b1; rsp1_ready = 1'b0;
    set_req(1'b1, 1'b1, 4'd1, 16'h0003, 16'h0004);
    #1;
    chk("bp_accept1", req1_ready, 1'b1);
    @(negedge clk);
    set_req(1'b1, 1'b0, 4'd1, 16'h0003, 16'h0004);
    set_req(1'b0, 1'b1, 4'd0, 16'h000A, 16'h0014);
    #1;
    chk("bp_exec_ready0", req0_ready, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      chk("bp_rsp1_valid", rsp1_valid, 1'b1);
      chk("bp_rsp0_valid", rsp0_valid, 1'b0);
      chk("bp_rsp_data", rsp_data, 16'hFFFF);
      chk("bp_flags", flag_reg, 3'b100);
      chk("bp_ready0", req0_ready, 1'b0);
    end
    @(negedge clk);
    rsp1_ready = 1'b1;
    #1;
    chk("bp_release_valid", rsp1_valid, 1'b1);
    chk("bp_release_ready0", req0_ready, 1'b0);
    @(negedge clk);
    rsp1_ready = 1'b0;
    #1;
    chk("bp_accept0", req0_ready, 1'b1);
    chk("bp_rsp1_dropped", rsp1_valid, 1'b0);
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk); #1;
    chk("bp_rsp0_valid_after", rsp0_valid, 1'b1);
    chk("bp_rsp0_data", rsp_data, 16'h001E);
    @(negedge clk); #1;
    chk("bp_idle", busy, 1'b0);

    // Reset during EXEC discards the operation and restores the tie order.
    do_reset();
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    set_req(1'b0, 1'b1, 4'd0, 16'h7FFF, 16'h0001);
    #1;
    chk("mid_accept", req0_ready, 1'b1);
    @(negedge clk);
    req0_valid = 1'b0;
    #1;
    chk("mid_exec_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_ready_in_rst", {req1_ready, req0_ready}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mid_busy", busy, 1'b0);
    chk("mid_flags", flag_reg, 3'b000);
    chk("mid_alu_in1", alu_in1, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("mid_no_rsp", {rsp1_valid, rsp0_valid}, 2'b00);
    end
    @(negedge clk);
    set_req(1'b0, 1'b1, 4'd1, 16'h0009, 16'h0009);
    set_req(1'b1, 1'b1, 4'd0, 16'h0001, 16'h0001);
    #1;
    chk("mid_tie_winner", {req1_ready, req0_ready}, 2'b01);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk); #1;
    chk("mid_tie_rsp", {rsp1_valid, rsp0_valid}, 2'b01);
    chk("mid_tie_data", rsp_data, 16'h0000);

    // Randomized traffic against a transaction-level model.
    do_reset();
    for (int r = 0; r < 2; r++) begin vr[r] = 1'b0; acc[r] = 1'b0; end
    outstanding = 1'b0; lg_m = 1'b1; flags_m = 3'b000; age = 0; owner = 1'b0; exp_d_m = 16'h0000;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      for (int r = 0; r < 2; r++) begin
        if (acc[r] || !vr[r]) begin
          acc[r] = 1'b0;
          vr[r]  = ($urandom_range(0, 2) != 0);
          opr[r] = op_pool[$urandom_range(0, 7)];
          ar[r]  = ($urandom_range(0, 3) == 0) ? 16'h7FFF : 16'($urandom);
          br[r]  = ($urandom_range(0, 3) == 0) ? 16'h0001 : 16'($urandom);
        end
      end
      set_req(1'b0, vr[0], opr[0], ar[0], br[0]);
      set_req(1'b1, vr[1], opr[1], ar[1], br[1]);
      rsp0_ready = ($urandom_range(0, 3) != 0);
      rsp1_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (outstanding) age++;
      chk("rnd_busy", busy, outstanding);
      if (!outstanding) begin
        win = (vr[0] && vr[1]) ? !lg_m : vr[1];
        er0 = vr[0] && !win;
        er1 = vr[1] && win;
        chk("rnd_ready", {req1_ready, req0_ready}, {er1, er0});
        chk("rnd_idle_flags", flag_reg, flags_m);
        chk("rnd_idle_rsp", {rsp1_valid, rsp0_valid}, 2'b00);
        if (er0 || er1) begin
          res         = alu_ref(opr[win], ar[win], br[win]);
          flags_m     = (flags_m & ~res.en) | (res.f & res.en);
          exp_d_m     = res.d;
          owner       = win;
          lg_m        = win;
          outstanding = 1'b1;
          age         = 0;
          acc[win]    = 1'b1;
        end
      end else begin
        chk("rnd_busy_ready", {req1_ready, req0_ready}, 2'b00);
        chk("rnd_rsp_valid", {rsp1_valid, rsp0_valid},
            (age >= 2) ? (owner ? 2'b10 : 2'b01) : 2'b00);
        if (age >= 2) begin
          chk("rnd_rsp_data", rsp_data, exp_d_m);
          chk("rnd_rsp_flags", flag_reg, flags_m);
          if (owner ? rsp1_ready : rsp0_ready) outstanding = 1'b0;
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Round-robin arbiter and sequencer that shares the single combinational ALU between two requesters, for example the main datapath and a multi-cycle helper unit. It accepts one operation at a time over a valid/ready handshake, drives the ALU from registered operands, and captures the result. It maintains the architectural N/Z/V flag register under the ALU's per-bit enable mask, then returns the result to the winning requester over a valid/ready response channel.

## Interface
Parameters:
- DATA_W, 16, operand/result width
- OP_W, 4, opcode width
- FLAG_W, 3, flag width; bit2=N, bit1=Z, bit0=V

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- req0_valid / req1_valid  in  1  requester N has an operation
- req0_ready / req1_ready  out  1  requester N's operation is accepted this cycle
- req0_opcode / req1_opcode  in  OP_W  ALU opcode
- req0_a / req1_a  in  DATA_W  operand 1
- req0_b / req1_b  in  DATA_W  operand 2
- alu_opcode  out  OP_W  to shared ALU Opcode
- alu_in1  out  DATA_W  to shared ALU operand 1
- alu_in2  out  DATA_W  to shared ALU operand 2
- alu_out  in  DATA_W  ALU result
- alu_flags  in  FLAG_W  ALU flags
- alu_enable  in  FLAG_W  ALU per-flag write enable
- rsp0_valid / rsp1_valid  out  1  result available for requester N
- rsp0_ready / rsp1_ready  in  1  requester N takes the result
- rsp_data  out  DATA_W  result, shared by both response channels
- flag_reg  out  FLAG_W  architectural flags
- busy  out  1  high in every state except IDLE

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE:**
  - reqN_ready is combinational and asserted only for the grant winner, and only if that requester's valid is high.
  - If only one requester is valid, it wins.
  - If both are valid, the requester not in last_grant wins.
  - On handshake, latch opcode, a and b into the issue registers, set last_grant to the winner, and go to EXEC.
- **EXEC (one cycle):**
  - alu_opcode, alu_in1 and alu_in2 come from the issue registers at all times, in every state.
  - Capture alu_out into rsp_data.
  - For each bit i: flag_reg[i] <= alu_enable[i] ? alu_flags[i] : flag_reg[i].
  - Go to RESP.
- **RESP:**
  - rspN_valid is high for the owner (last_grant) only.
  - rsp_data and rspN_valid are held stable until rspN_ready is high. On that cycle go to IDLE.
  - A rspN_ready for the non-owner is ignored.
- No reqN_ready is asserted outside IDLE. New requests wait in IDLE-less states with no loss; requesters must hold valid and payload stable until ready.
- Opcodes are forwarded unmodified. LW/SW (8/9) and undefined opcodes are arbitrated identically. Their ALU enable of 000 leaves flag_reg unchanged.
- **Reset (rst_n low at a clock edge), from any state including mid-EXEC or RESP:**
  - State goes to IDLE, and an in-flight operation is discarded with no response.
  - flag_reg=000, rsp_data=0, issue registers=0 (so alu_opcode=0, alu_in1=0, alu_in2=0), last_grant=1 so requester 0 wins the first tie.
  - rsp0_valid=0, rsp1_valid=0, busy=0.
  - req0_ready and req1_ready are 0 while rst_n is low.

## Timing
- Cycle T: accept (valid & ready in IDLE).
- Cycle T+1: EXEC; ALU inputs already reflect the issue registers from T+1.
- Cycle T+2: rspN_valid=1 with rsp_data, and flag_reg updated, both visible from T+2.
- Minimum accept-to-response latency is 2 cycles.
- If rspN_ready=1 at T+2, the next accept is possible at T+3, giving a peak throughput of 1 operation per 3 cycles.
- Response backpressure adds one cycle per stalled cycle; flag_reg does not change during the stall.
- Arbitration is fair: with both requesters continuously valid, grants strictly alternate, starting with 0 after reset.

## Test plan
- **Reset values:** hold rst_n=0 for 2 cycles with both req valid → both ready=0; busy=0; rsp valids=0; flag_reg=000; alu_opcode=0, alu_in1=0, alu_in2=0.
- **Single add:** req0 ADD(0) a=5 b=7 at T → req0_ready=1 at T; alu_in1=5, alu_in2=7 at T+1; rsp0_valid=1 and rsp_data=12 at T+2; flag_reg=000.
- **Overflow, then masked flag update:**
  - ADD 0x7FFF+0x0001 → rsp_data=0x8000, flag_reg=101.
  - Then XOR(2) 0x1234^0x1234 → rsp_data=0, flag_reg=111; N and V are kept because the ALU enable is 010.
- **Simultaneous requests:** both valid with ops SUB 9−9 (req0) and ADD 1+1 (req1), rsp_ready tied high → grant order is 0, 1, 0, …; rsp0 data=0 with Z set; rsp1 data=2; no grant while busy.
- **Backpressure:** hold rsp1_ready=0 for 4 cycles → rsp1_valid and rsp_data stay stable; req0 is held pending with ready=0; req0 is accepted 1 cycle after rsp1_ready rises.
- **Reset mid-operation:** pulse rst_n=0 during EXEC → next cycle IDLE, no rsp_valid ever for that operation, flag_reg=000, requester 0 wins the next tie.
